// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-ported word memory between the
// instruction-fetch port and the load/store port of the core.
// Data requests win arbitration. Each accepted request gets one memory
// access cycle (ACCESS), then a one-cycle response pulse (RESP) to its owner.
// Optional build macro ARB_STARVE_GUARD_EN adds a starvation counter. When the
// counter saturates, fetch is forced to win over data.
module mem_port_arbiter #(
  parameter int ADDR_W       = 6,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  input  logic [3:0]        d_be,
  output logic              d_ready,
  output logic              d_rvalid,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [3:0]        mem_be,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state;
  state_t state_next;

  // Registered copy of the winning request. lat_owner is 1 for data and 0 for fetch.
  logic [ADDR_W-1:0] lat_addr;
  logic              lat_we;
  logic [3:0]        lat_be;
  logic [DATA_W-1:0] lat_wdata;
  logic              lat_owner;

  // Per-port response registers.
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;

  logic accept_window;
  logic force_fetch;
  logic accept;

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_cnt;

  // Count consecutive lost arbitrations of a pending fetch, saturating at the limit.
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!if_req || if_ready) begin
      starve_cnt <= '0;
    end else if (d_ready && (starve_cnt != CNT_MAX)) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  assign force_fetch = if_req && (starve_cnt == CNT_MAX);
`else
  // Strict data priority: an int limit is never negative, so fetch is never forced.
  assign force_fetch = (STARVE_LIMIT < 0);
`endif

  // New requests are taken in IDLE and RESP, never while reset is held.
  assign accept_window = !rst && ((state == IDLE) || (state == RESP));
  assign accept        = if_ready || d_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. ACCESS always takes exactly one cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = accept ? ACCESS : IDLE;
      ACCESS:  state_next = RESP;
      RESP:    state_next = accept ? ACCESS : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode: arbitration readies, memory strobes, response pulses.
  always_comb begin
    d_ready   = 1'b0;
    if_ready  = 1'b0;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    if_rvalid = 1'b0;
    d_rvalid  = 1'b0;
    busy      = (state != IDLE);
    if (accept_window) begin
      if (d_req && !force_fetch) begin
        d_ready = 1'b1;
      end else if (if_req) begin
        if_ready = 1'b1;
      end
    end
    if (state == ACCESS) begin
      mem_en = 1'b1;
      mem_we = lat_we;
    end
    if (state == RESP) begin
      d_rvalid  = lat_owner;
      if_rvalid = !lat_owner;
    end
  end

  // Latch the winning request. Fetch is always a full-word read.
  always_ff @(posedge clk) begin
    if (rst) begin
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_be    <= '0;
      lat_wdata <= '0;
      lat_owner <= 1'b0;
    end else if (d_ready) begin
      lat_addr  <= d_addr;
      lat_we    <= d_we;
      lat_be    <= d_be;
      lat_wdata <= d_wdata;
      lat_owner <= 1'b1;
    end else if (if_ready) begin
      lat_addr  <= if_addr;
      lat_we    <= 1'b0;
      lat_be    <= 4'hF;
      lat_wdata <= '0;
      lat_owner <= 1'b0;
    end
  end

  // Capture read data at the end of ACCESS into the owner's response register.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else if (state == ACCESS) begin
      if (lat_owner) begin
        d_rdata_q <= lat_we ? '0 : mem_rdata;
      end else begin
        if_rdata_q <= mem_rdata;
      end
    end
  end

  // The latches only change on acceptance, so memory address, byte enables and
  // write data hold their values outside ACCESS.
  assign mem_addr  = lat_addr;
  assign mem_be    = lat_be;
  assign mem_wdata = lat_wdata;
  assign if_rdata  = if_rdata_q;
  assign d_rdata   = d_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: table-driven check of mem_port_arbiter against a
// behavioural 64 x 32 memory, plus hand-written starvation and reset sequences.
// Expected starvation behaviour follows the ARB_STARVE_GUARD_EN build macro.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [5:0]  if_addr;
  logic        if_ready;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        d_req;
  logic        d_we;
  logic [5:0]  d_addr;
  logic [31:0] d_wdata;
  logic [3:0]  d_be;
  logic        d_ready;
  logic        d_rvalid;
  logic [31:0] d_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [5:0]  mem_addr;
  logic [3:0]  mem_be;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        busy;

  logic [31:0] mem [64];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst;
    logic        if_req;
    logic [5:0]  if_addr;
    logic        d_req;
    logic        d_we;
    logic [5:0]  d_addr;
    logic [31:0] d_wdata;
    logic        e_if_ready;
    logic        e_d_ready;
    logic        e_if_rvalid;
    logic [31:0] e_if_rdata;
    logic        e_d_rvalid;
    logic [31:0] e_d_rdata;
    logic        e_mem_en;
    logic        e_mem_we;
    logic [5:0]  e_mem_addr;
    logic        e_busy;
  } vec_t;

  localparam int NVEC = 18;
  vec_t vecs [NVEC];

  mem_port_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ready  (if_ready),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .d_req     (d_req),
    .d_we      (d_we),
    .d_addr    (d_addr),
    .d_wdata   (d_wdata),
    .d_be      (d_be),
    .d_ready   (d_ready),
    .d_rvalid  (d_rvalid),
    .d_rdata   (d_rdata),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_be    (mem_be),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Behavioural single-port memory: combinational read, byte-enabled write.
  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (mem_be[b]) mem[mem_addr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  // Watchdog so the bench can never hang.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mk(
    input logic r, input logic ir, input logic [5:0] ia,
    input logic dr, input logic dw, input logic [5:0] da, input logic [31:0] dwd,
    input logic eir, input logic edr, input logic eiv, input logic [31:0] eid,
    input logic edv, input logic [31:0] edd, input logic een, input logic ewe,
    input logic [5:0] ema, input logic eb);
    vec_t v;
    v.rst = r; v.if_req = ir; v.if_addr = ia;
    v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = dwd;
    v.e_if_ready = eir; v.e_d_ready = edr; v.e_if_rvalid = eiv; v.e_if_rdata = eid;
    v.e_d_rvalid = edv; v.e_d_rdata = edd; v.e_mem_en = een; v.e_mem_we = ewe;
    v.e_mem_addr = ema; v.e_busy = eb;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    rst     = v.rst;
    if_req  = v.if_req;
    if_addr = v.if_addr;
    d_req   = v.d_req;
    d_we    = v.d_we;
    d_addr  = v.d_addr;
    d_wdata = v.d_wdata;
    d_be    = 4'hF;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic checkVec(input int i, input vec_t v);
    checkOutput($sformatf("v%0d.if_ready", i),  32'(if_ready),  32'(v.e_if_ready));
    checkOutput($sformatf("v%0d.d_ready", i),   32'(d_ready),   32'(v.e_d_ready));
    checkOutput($sformatf("v%0d.if_rvalid", i), 32'(if_rvalid), 32'(v.e_if_rvalid));
    checkOutput($sformatf("v%0d.if_rdata", i),  if_rdata,       v.e_if_rdata);
    checkOutput($sformatf("v%0d.d_rvalid", i),  32'(d_rvalid),  32'(v.e_d_rvalid));
    checkOutput($sformatf("v%0d.d_rdata", i),   d_rdata,        v.e_d_rdata);
    checkOutput($sformatf("v%0d.mem_en", i),    32'(mem_en),    32'(v.e_mem_en));
    checkOutput($sformatf("v%0d.mem_we", i),    32'(mem_we),    32'(v.e_mem_we));
    checkOutput($sformatf("v%0d.mem_addr", i),  32'(mem_addr),  32'(v.e_mem_addr));
    checkOutput($sformatf("v%0d.busy", i),      32'(busy),      32'(v.e_busy));
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  // Which accept in a continuous-contention run should go to fetch.
  function automatic logic expectFetch(input int n);
`ifdef ARB_STARVE_GUARD_EN
    return ((n % 5) == 4);
`else
    return (n < 0);
`endif
  endfunction

  initial begin
    int accepts;
    int fetches;
    int cycles;
    logic is_fetch;

    for (int i = 0; i < 64; i++) mem[i] = 32'h0;
    mem[2] = 32'h00802b83;
    mem[7] = 32'h12345678;
    mem[9] = 32'hCAFEF00D;

    //           rst ir ia dr dw da dwdata          eir edr eiv eid           edv edd           een ewe ema eb
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 32'h0,          0, 32'h0,          0, 0, 0, 0);
    vecs[1]  = mk(1, 1, 2, 0, 0, 0, 32'h0,          0, 0, 0, 32'h0,          0, 32'h0,          0, 0, 0, 0);
    vecs[2]  = mk(0, 1, 2, 0, 0, 0, 32'h0,          1, 0, 0, 32'h0,          0, 32'h0,          0, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 32'h0,          0, 32'h0,          1, 0, 2, 1);
    vecs[4]  = mk(0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 1, 32'h00802b83,   0, 32'h0,          0, 0, 2, 1);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 32'h00802b83,   0, 32'h0,          0, 0, 2, 0);
    vecs[6]  = mk(0, 0, 0, 1, 1, 5, 32'hDEADBEEF,   0, 1, 0, 32'h00802b83,   0, 32'h0,          0, 0, 2, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 32'h00802b83,   0, 32'h0,          1, 1, 5, 1);
    vecs[8]  = mk(0, 0, 0, 1, 0, 5, 32'h0,          0, 1, 0, 32'h00802b83,   1, 32'h0,          0, 0, 5, 1);
    vecs[9]  = mk(0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 32'h00802b83,   0, 32'h0,          1, 0, 5, 1);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 32'h00802b83,   1, 32'hDEADBEEF,   0, 0, 5, 1);
    vecs[11] = mk(0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 32'h00802b83,   0, 32'hDEADBEEF,   0, 0, 5, 0);
    vecs[12] = mk(0, 1, 7, 1, 0, 9, 32'h0,          0, 1, 0, 32'h00802b83,   0, 32'hDEADBEEF,   0, 0, 5, 0);
    vecs[13] = mk(0, 1, 7, 0, 0, 0, 32'h0,          0, 0, 0, 32'h00802b83,   0, 32'hDEADBEEF,   1, 0, 9, 1);
    vecs[14] = mk(0, 1, 7, 0, 0, 0, 32'h0,          1, 0, 0, 32'h00802b83,   1, 32'hCAFEF00D,   0, 0, 9, 1);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 32'h00802b83,   0, 32'hCAFEF00D,   1, 0, 7, 1);
    vecs[16] = mk(0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 1, 32'h12345678,   0, 32'hCAFEF00D,   0, 0, 7, 1);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 32'h0,          0, 0, 0, 32'h12345678,   0, 32'hCAFEF00D,   0, 0, 7, 0);

    // Bring the design out of its unknown power-up state before checking.
    applyStimulus(vecs[0]);
    nextCycle();

    for (int i = 0; i < NVEC; i++) begin
      applyStimulus(vecs[i]);
      #1;
      checkVec(i, vecs[i]);
      nextCycle();
    end

    // Continuous contention: both ports hold requests for 20 accepts.
    if_req = 1'b1; if_addr = 6'd7;
    d_req = 1'b1; d_we = 1'b0; d_addr = 6'd9; d_wdata = 32'h0;
    accepts = 0;
    fetches = 0;
    cycles  = 0;
    while (accepts < 20 && cycles < 200) begin
      #1;
      if (if_ready && d_ready) checkOutput("starve.dual_ready", 32'd1, 32'd0);
      if (if_rvalid && d_rvalid) checkOutput("starve.rvalid_overlap", 32'd1, 32'd0);
      if (if_ready || d_ready) begin
        is_fetch = if_ready;
        if (is_fetch) fetches++;
        checkOutput($sformatf("starve.accept%0d_is_fetch", accepts), 32'(is_fetch), 32'(expectFetch(accepts)));
        accepts++;
      end
      nextCycle();
      cycles++;
    end
    checkOutput("starve.accepts", 32'(accepts), 32'd20);
`ifdef ARB_STARVE_GUARD_EN
    checkOutput("starve.fetch_wins", 32'(fetches), 32'd4);
`else
    checkOutput("starve.fetch_wins", 32'(fetches), 32'd0);
`endif

    // Drain to IDLE.
    if_req = 1'b0;
    d_req  = 1'b0;
    cycles = 0;
    while (busy && cycles < 10) begin
      nextCycle();
      cycles++;
    end
    checkOutput("drain.busy", 32'(busy), 32'd0);

    // Reset during ACCESS of a load aborts it.
    d_req = 1'b1; d_we = 1'b0; d_addr = 6'd9;
    #1;
    checkOutput("rstacc.d_ready", 32'(d_ready), 32'd1);
    nextCycle();
    d_req = 1'b0;
    rst   = 1'b1;
    #1;
    checkOutput("rstacc.mem_en_in_access", 32'(mem_en), 32'd1);
    nextCycle();
    rst = 1'b0;
    #1;
    checkOutput("rstacc.busy",      32'(busy),      32'd0);
    checkOutput("rstacc.mem_en",    32'(mem_en),    32'd0);
    checkOutput("rstacc.mem_we",    32'(mem_we),    32'd0);
    checkOutput("rstacc.mem_addr",  32'(mem_addr),  32'd0);
    checkOutput("rstacc.d_rvalid",  32'(d_rvalid),  32'd0);
    checkOutput("rstacc.if_rvalid", 32'(if_rvalid), 32'd0);
    checkOutput("rstacc.d_rdata",   d_rdata,        32'h0);
    checkOutput("rstacc.if_rdata",  if_rdata,       32'h0);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkOutput($sformatf("rstacc.no_rvalid%0d", i), 32'(d_rvalid), 32'd0);
    end

    // Re-present the load; it must complete normally two cycles after accept.
    d_req = 1'b1;
    cycles = 0;
    #1;
    while (!d_ready && cycles < 10) begin
      nextCycle();
      cycles++;
    end
    checkOutput("retry.d_ready", 32'(d_ready), 32'd1);
    nextCycle();
    d_req = 1'b0;
    nextCycle();
    checkOutput("retry.d_rvalid", 32'(d_rvalid), 32'd1);
    checkOutput("retry.d_rdata",  d_rdata,       32'hCAFEF00D);
    nextCycle();
    checkOutput("retry.d_rvalid_pulse", 32'(d_rvalid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer sharing one single-ported unified word memory (64 x 32 by default) between the instruction-fetch path and the load/store path of the RISC-V core. It accepts requests from both ports through a valid/ready handshake and registers the winning request. It drives the memory for exactly one access cycle, then returns read data with a one-cycle response pulse to the port that issued the request. Data accesses have priority. An optional starvation guard bounds how long fetch can be locked out.

## Interface
- ADDR_W, 6, word address width (64 words)
- DATA_W, 32, data word width
- STARVE_LIMIT, 4, consecutive lost arbitrations before fetch is forced to win (used only with guard enabled)

- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request valid; must stay asserted with stable if_addr until if_ready
- if_addr  in  ADDR_W  fetch word address
- if_ready  out  1  fetch request accepted this cycle
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DATA_W  fetched instruction word
- d_req  in  1  data request valid; held with stable payload until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data word address
- d_wdata  in  DATA_W  store data
- d_be  in  4  store byte enables
- d_ready  out  1  data request accepted this cycle
- d_rvalid  out  1  one-cycle pulse: load data returned or store completed
- d_rdata  out  DATA_W  load word; 0 for stores
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_W  memory word address
- mem_be  out  4  memory byte enables
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, combinational from mem_addr
- busy  out  1  state is not IDLE

## Operation
- States are IDLE, ACCESS and RESP.
- Acceptance is possible in IDLE or RESP.
  - If d_req=1, d_ready=1.
  - Else if if_req=1, if_ready=1.
  - At most one ready per cycle. Readies are combinational from req and state.
- On acceptance:
  - Latch addr, we, be, wdata and owner. Fetch latches we=0 and be=4'hF.
  - Next state is ACCESS.
- RESP with no acceptance goes to IDLE.
- ACCESS:
  - mem_en=1, mem_we=latched we, mem_addr/mem_be/mem_wdata come from the latches.
  - At the end of the cycle, capture mem_rdata into the response register (0 if we=1).
  - Next state is RESP, unconditionally.
- RESP:
  - Owner's rvalid=1 for exactly one cycle, and its rdata comes from the response register.
  - The non-owner's rvalid=0.
  - rdata holds its value until the next RESP.
- Outside ACCESS: mem_en=0, mem_we=0. mem_addr, mem_be and mem_wdata hold their last values.
- Starvation counter (guard only):
  - Width is clog2(STARVE_LIMIT+1), saturating at STARVE_LIMIT.
  - Increments when if_req=1 and data wins.
  - Clears when fetch is accepted or if_req=0.
  - While the count equals STARVE_LIMIT and if_req=1, fetch wins over data.
- A store followed by a load to the same address returns the stored data. No write buffering, so ordering is strictly acceptance order.

## Timing
- Request accepted at edge k (ready high in cycle k-1 → edge k):
  - ACCESS in cycle k.
  - Response captured at edge k+1.
  - rvalid high in cycle k+1.
- Latency from acceptance to rvalid is 2 cycles.
- Back-to-back: a new request can be accepted in the RESP cycle, giving peak throughput of one access per 2 cycles.
- Simultaneous if_req and d_req: data wins (unless the guard forces fetch). The loser keeps its request asserted and is reconsidered in the next RESP/IDLE cycle.
- Reset values:
  - State IDLE.
  - All ready and rvalid outputs 0.
  - if_rdata, d_rdata, mem_* and latched registers all 0.
  - busy 0, starvation counter 0.
- Reset in ACCESS or RESP aborts the transaction. No rvalid is issued. Reset in ACCESS deasserts mem_en/mem_we in the cycle after the reset edge. A write in that ACCESS cycle may or may not have completed; software must not rely on it.
- Requests presented during rst=1 are not accepted.

## Configuration
- ARB_STARVE_GUARD_EN defined: the starvation counter and forced fetch win are present as described.
- ARB_STARVE_GUARD_EN undefined: strict data priority. The counter logic is not compiled. STARVE_LIMIT is ignored. Continuous d_req starves fetch indefinitely.

## Test plan
- Single fetch of if_addr=2 with mem[2]=32'h00802b83 → if_ready in cycle 0, mem_en in cycle 1, if_rvalid with if_rdata=32'h00802b83 in cycle 2, busy back to 0 in cycle 3.
- Store d_addr=5, d_wdata=32'hDEADBEEF, d_be=4'hF, then load d_addr=5 → store d_rvalid with d_rdata=0, then load d_rvalid with d_rdata=32'hDEADBEEF. Accepts 2 cycles apart.
- if_req and d_req asserted in the same cycle → d_ready first, if_ready in the data RESP cycle. if_rvalid appears 2 cycles after d_rvalid, with no overlap of the rvalids.
- Guard enabled, STARVE_LIMIT=4, d_req and if_req held high → 4 data accepts, then 1 fetch accept, then data again. Guard disabled → no fetch accept within 20 accepts.
- rst asserted for one cycle during ACCESS of a load → no d_rvalid afterward. State IDLE, all outputs 0. The request re-presented after reset completes normally.
